// File: rtl/alu_func_unit.sv
// R-type execution unit: single-cycle ALU ops plus an iterative mult/div sequencer writing HI/LO.
// Define ALU_FUNC_DIV_EN to build the restoring divider and its divide-by-zero handling.
module alu_func_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_MULT = 6'b011000;
  localparam logic [5:0] F_DIV  = 6'b011010;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_MOVE = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t               state, state_n;
  logic [2*WIDTH-1:0]   acc, acc_n;     // {upper, lower} working register for mult/div
  logic [WIDTH-1:0]     opnd, opnd_n;   // multiplicand or divisor
  logic [SHW-1:0]       cnt, cnt_n;
  logic [WIDTH-1:0]     result_n, hi_n, lo_n;
  logic                 illegal_n;

  // One shift-add step: conditionally add the multiplicand to the upper half, then shift right.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

`ifdef ALU_FUNC_DIV_EN
  // One restoring step; the shifted partial remainder needs WIDTH+1 bits when the divisor MSB is set.
  logic [WIDTH:0]       div_rem_sh, div_trial;
  logic [2*WIDTH-1:0]   div_next;

  always_comb begin
    div_rem_sh = acc[2*WIDTH-1:WIDTH-1];
    div_trial  = div_rem_sh - {1'b0, opnd};
    div_next   = div_trial[WIDTH] ? {div_rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                  : {div_trial[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
  end
`endif

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n   = state;
    acc_n     = acc;
    opnd_n    = opnd;
    cnt_n     = cnt;
    result_n  = result;
    hi_n      = hi;
    lo_n      = lo;
    illegal_n = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        state_n = S_IDLE;
        if (start) begin
          state_n = S_DONE;
          cnt_n   = '0;
          case (func)
            F_ADD:         result_n = a + b;
            F_SUB:         result_n = a - b;
            F_SLT:         result_n = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            F_OR:          result_n = a | b;
            F_AND:         result_n = a & b;
            F_NOR:         result_n = ~(a | b);
            F_SLL:         result_n = b << shamt;
            F_SRL:         result_n = b >> shamt;
            F_MOVE, F_JR:  result_n = a;
            F_MFHI:        result_n = hi;
            F_MFLO:        result_n = lo;
            F_MULT: begin
              state_n = S_MUL;
              acc_n   = {{WIDTH{1'b0}}, b};
              opnd_n  = a;
            end
`ifdef ALU_FUNC_DIV_EN
            F_DIV: begin
              if (b == '0) begin
                result_n = '1;
                lo_n     = '1;
                hi_n     = a;
              end else begin
                state_n = S_DIV;
                acc_n   = {{WIDTH{1'b0}}, a};
                opnd_n  = b;
              end
            end
`endif
            default: begin
              result_n  = '0;
              illegal_n = 1'b1;
            end
          endcase
        end
      end

      S_MUL: begin
        acc_n = mul_next;
        cnt_n = cnt + SHW'(1);
        if (cnt == SHW'(WIDTH-1)) begin
          state_n  = S_DONE;
          cnt_n    = '0;
          hi_n     = mul_next[2*WIDTH-1:WIDTH];
          lo_n     = mul_next[WIDTH-1:0];
          result_n = mul_next[WIDTH-1:0];
        end
      end

`ifdef ALU_FUNC_DIV_EN
      S_DIV: begin
        acc_n = div_next;
        cnt_n = cnt + SHW'(1);
        if (cnt == SHW'(WIDTH-1)) begin
          state_n  = S_DONE;
          cnt_n    = '0;
          hi_n     = div_next[2*WIDTH-1:WIDTH];
          lo_n     = div_next[WIDTH-1:0];
          result_n = div_next[WIDTH-1:0];
        end
      end
`endif

      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      acc     <= '0;
      opnd    <= '0;
      cnt     <= '0;
      result  <= '0;
      hi      <= '0;
      lo      <= '0;
      illegal <= 1'b0;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      opnd    <= opnd_n;
      cnt     <= cnt_n;
      result  <= result_n;
      hi      <= hi_n;
      lo      <= lo_n;
      illegal <= illegal_n;
    end
  end

  assign busy = (state == S_MUL) || (state == S_DIV);
  assign done = (state == S_DONE);

endmodule

// File: doc/alu_func_unit.md
# alu_func_unit

Parametrised R-type execution unit for the MIPS datapath: decodes the 6-bit `func` field and executes the operation on WIDTH-bit operands. Single-cycle ops (add, sub, slt, or, and, nor, sll, srl, move, jr, mfhi, mflo) complete in one cycle. `mult` and `div` run on an iterative shift-add / restoring-divide sequencer that writes the HI/LO registers. It sits in the execute stage, replacing the combinational func-to-ALUOp decode plus ALU pair, and uses a start/busy/done handshake with the control unit.

## Interface
Parameters:
- `WIDTH`, default 32: operand, result, HI and LO width; must be a power of two, ≥ 8.
- `SHW`, default $clog2(WIDTH): shift-amount width.

Ports:
- `clk`  in  1  rising-edge clock for all state.
- `reset`  in  1  synchronous, active-high reset; sampled on `clk`.
- `start`  in  1  request; accepted only in a cycle where `busy`=0.
- `func`  in  6  R-type function code, sampled with `start`.
- `shamt`  in  SHW  shift amount, sampled with `start`.
- `a`  in  WIDTH  rs operand, sampled with `start`.
- `b`  in  WIDTH  rt operand, sampled with `start`.
- `result`  out  WIDTH  registered result; holds until the next `done`.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `busy`  out  1  high while a mult/div is iterating.
- `done`  out  1  one-cycle pulse when `result` is valid.
- `illegal`  out  1  one-cycle pulse with `done` for an undefined func.

## Operation
- FSM states: IDLE, MUL, DIV, DONE. Reset enters IDLE.
- Reset values: `result`, `hi` and `lo` = 0; `busy`, `done` and `illegal` = 0; iteration counter = 0.
- Accepted `start` with a single-cycle func: go to DONE with the registered result.
- Single-cycle func decode:
  - 100000 add: a+b, wrap, no overflow trap.
  - 100010 sub: a−b, wrap.
  - 101010 slt: signed a<b gives 1, else 0.
  - 100101 or, 100100 and, 100111 nor: bitwise.
  - 000000 sll: b<<shamt.
  - 000010 srl: logical b>>shamt.
  - 100001 move: result = a.
  - 001000 jr: result = a.
  - 010000 mfhi: result = hi.
  - 010010 mflo: result = lo.
- 011000 mult: go to MUL. Unsigned product. Runs WIDTH iterations of one shift-add per cycle on a 2·WIDTH accumulator. On exit, `hi` = upper half, `lo` = lower half, `result` = lower half.
- 011010 div: go to DIV. Unsigned restoring divide, WIDTH iterations, one quotient bit per cycle. On exit, `lo` = quotient, `hi` = remainder, `result` = quotient.
- Divide by zero (b=0): no iteration; go straight to DONE with `lo` = all ones, `hi` = a, `result` = all ones.
- Any other func: `result` = 0, `illegal` pulses with `done`, and `hi`/`lo` are unchanged.
- DONE always returns to IDLE the next cycle. `start` in DONE is accepted, giving back-to-back operation.
- `hi` and `lo` change only on mult/div completion or on reset.

## Timing
- Timing is stated relative to `start` accepted at cycle N.
- Single-cycle ops: `done`, `result` and `illegal` are valid at N+1. `busy` is never asserted.
- mult/div: `busy`=1 during cycles N+1 … N+WIDTH. `done`=1 and `busy`=0 at N+WIDTH+1, where `hi`, `lo` and `result` are updated. For WIDTH=32, done is at N+33.
- Divide by zero: `done` at N+1, and `busy` is never asserted.
- `start` while `busy`=1 is ignored; operands are not resampled.
- `reset` mid-iteration aborts the operation. Next cycle: IDLE with all outputs at reset values, and no `done` is produced for the aborted operation.
- `reset` has priority over `start` in the same cycle.

## Configuration
- `ALU_FUNC_DIV_EN` defined: the DIV state, the divider datapath and divide-by-zero handling are built as specified.
- `ALU_FUNC_DIV_EN` undefined: no divider hardware. func 011010 is treated as undefined: `done`+`illegal` at N+1, `result`=0, `hi`/`lo` unchanged.

## Test plan
- Reset, then add a=0x7FFFFFFF, b=1 → result 0x80000000, done at N+1, busy stays 0. Then slt a=0xFFFFFFFF, b=0 → result 1.
- sll b=0x00000001, shamt=31 → result 0x80000000. Then srl b=0x80000000, shamt=31 → result 0x00000001.
- mult a=0xFFFFFFFF, b=2 → busy N+1..N+32, done at N+33, hi=0x00000001, lo=0xFFFFFFFE. Then mfhi → result 0x00000001.
- div a=100, b=7 → done at N+33, lo=14, hi=2. Then div a=5, b=0 → done at N+1, lo=0xFFFFFFFF, hi=5. With macro undefined: illegal=1 and hi/lo unchanged.
- mult started, `start`+add issued at N+5 → ignored, mult completes normally. `reset` at N+10 of a second mult → no done, hi=lo=result=0.
- func 111111 → done+illegal at N+1, result 0, hi/lo unchanged. Back-to-back start in the DONE cycle is accepted.
